fifo_drain_control: RTL and testbench

//  Read-side counterpart of the FIFO fill controller. Drains the per-lane im2col FIFOs into the

---
 rtl/fifo_drain_control_pkg.sv | 13 +
 rtl/drain_lane_window.sv | 19 +
 rtl/fifo_drain_control.sv | 183 ++++++++++++++++++
 tb/tb_fifo_drain_control.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_control_pkg.sv
// Shared definitions for the im2col lane FIFO fill/drain controllers.
package fifo_drain_control_pkg;

  localparam int CNT_SIZE = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/drain_lane_window.sv
// Per-lane beat window: lane is scheduled while k <= t < k+n.
module drain_lane_window
  import fifo_drain_control_pkg::*;
#(
  parameter int cnt_size = CNT_SIZE
) (
  input  logic [cnt_size-1:0] t,
  input  logic [cnt_size-1:0] k,
  input  logic [cnt_size-1:0] n,
  input  logic                lane_active,
  output logic                sched
);

  // subtract only after t>=k so the window test cannot wrap
  assign sched = lane_active
               && (t >= k)
               && ((t - k) < n);

endmodule

// File: rtl/fifo_drain_control.sv
// Skewed drain of per-lane im2col FIFOs into the systolic array.
module fifo_drain_control
  import fifo_drain_control_pkg::*;
#(
  parameter int array_size    = 9,
  parameter int dim_data_size = 16,
  parameter int cnt_size      = CNT_SIZE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     start,
  input  logic [dim_data_size-1:0] weight_size,
  input  logic [dim_data_size-1:0] image_height,
  input  logic [dim_data_size-1:0] image_width,
  input  logic [7:0]               offset,
  input  logic [array_size-1:0]    fifo_empty,
  output logic [array_size-1:0]    read_enable_out,
  output logic [array_size-1:0]    valid_out,
  output logic                     busy,
  output logic                     completed
);

  state_e state_q, state_d;

  logic [dim_data_size-1:0] k_q, k_d;
  logic [dim_data_size-1:0] h_q, h_d;
  logic [dim_data_size-1:0] w_q, w_d;
  logic [7:0]               off_q, off_d;

  logic [cnt_size-1:0] n_q, n_d;
  logic [cnt_size-1:0] l_q, l_d;
  logic [cnt_size-1:0] tend_q, tend_d;
  logic [cnt_size-1:0] t_q, t_d;

  logic busy_q, busy_d;
  logic done_q, done_d;

  logic [array_size-1:0] valid_q;
  logic [array_size-1:0] sched;
  logic [array_size-1:0] re;
  logic                  fire;
  logic                  degen;

  logic [cnt_size-1:0] k_ext, h_ext, w_ext;
  logic [cnt_size-1:0] off_ext, kk, span;
  logic [cnt_size-1:0] n_calc, l_calc;

  always_comb begin
    k_ext   = cnt_size'(k_q);
    h_ext   = cnt_size'(h_q);
    w_ext   = cnt_size'(w_q);
    off_ext = cnt_size'(off_q);
    kk      = k_ext * k_ext;
    span    = cnt_size'(array_size) - off_ext;
    if (off_ext >= cnt_size'(array_size))
      l_calc = '0;
    else if (kk < span)
      l_calc = kk;
    else
      l_calc = span;
    degen = (k_q == '0) || (k_q > h_q)
         || (k_q > w_q) || (l_calc == '0);
    n_calc = degen ? '0 :
      (h_ext - k_ext + cnt_size'(1))
      * (w_ext - k_ext + cnt_size'(1));
  end

  for (genvar i = 0; i < array_size; i++) begin : g_lane
    logic [cnt_size-1:0] idx;
    logic [cnt_size-1:0] lk;
    logic                act;

    assign idx = cnt_size'(i);
    assign lk  = idx - off_ext;
    assign act = (idx >= off_ext)
              && (idx < off_ext + l_q);

    drain_lane_window #(
      .cnt_size(cnt_size)
    ) u_win (
      .t          (t_q),
      .k          (lk),
      .n          (n_q),
      .lane_active(act),
      .sched      (sched[i])
    );
  end

  // one empty scheduled lane stalls the whole wavefront
  assign fire = (state_q == ST_DRAIN) && enable
             && !(|(sched & fifo_empty));
  assign re   = fire ? sched : '0;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    h_d     = h_q;
    w_d     = w_q;
    off_d   = off_q;
    n_d     = n_q;
    l_d     = l_q;
    tend_d  = tend_q;
    t_d     = t_q;
    busy_d  = busy_q;
    done_d  = done_q;
    if (enable) begin
      unique case (state_q)
        ST_IDLE, ST_FINISH: begin
          if (start) begin
            k_d     = weight_size;
            h_d     = image_height;
            w_d     = image_width;
            off_d   = offset;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          n_d    = n_calc;
          l_d    = l_calc;
          tend_d = n_calc + l_calc - cnt_size'(1);
          t_d    = '0;
          if (degen) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_FINISH;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fire) begin
            t_d = t_q + cnt_size'(1);
            if (t_q == tend_q - cnt_size'(1)) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = ST_FINISH;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      h_q     <= '0;
      w_q     <= '0;
      off_q   <= '0;
      n_q     <= '0;
      l_q     <= '0;
      tend_q  <= '0;
      t_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      h_q     <= h_d;
      w_q     <= w_d;
      off_q   <= off_d;
      n_q     <= n_d;
      l_q     <= l_d;
      tend_q  <= tend_d;
      t_q     <= t_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= re;
    end
  end

  assign read_enable_out = re;
  assign valid_out       = valid_q;
  assign busy            = busy_q;
  assign completed       = done_q;

endmodule

// File: tb/tb_fifo_drain_control.sv
// Scoreboard bench for fifo_drain_control: per-beat pop vectors.
module tb_fifo_drain_control;

  localparam int AS = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          start;
  logic [15:0]   weight_size;
  logic [15:0]   image_height;
  logic [15:0]   image_width;
  logic [7:0]    offset;
  logic [AS-1:0] fifo_empty;
  logic [AS-1:0] read_enable_out;
  logic [AS-1:0] valid_out;
  logic          busy;
  logic          completed;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AS-1:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_drain_control dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .start          (start),
    .weight_size    (weight_size),
    .image_height   (image_height),
    .image_width    (image_width),
    .offset         (offset),
    .fifo_empty     (fifo_empty),
    .read_enable_out(read_enable_out),
    .valid_out      (valid_out),
    .busy           (busy),
    .completed      (completed)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic run_pass(
    input string name,
    input int k, input int h, input int w,
    input int off,
    input int st_lane, input int st_beat,
    input int st_len,
    input int en_beat, input int en_len,
    input int start_cyc, input int abort_beat,
    input logic [AS-1:0] bg
  );
    int n, l, tt, beats, pops, done_c;
    int st_cnt, en_cnt;
    logic stall;
    logic [AS-1:0] amask, prev, exp, fe, cur;
    n = (k == 0 || k > h || k > w) ? 0
      : (h - k + 1) * (w - k + 1);
    l = (off >= AS) ? 0
      : ((k * k < AS - off) ? k * k : AS - off);
    if (l == 0) n = 0;
    tt = (n == 0) ? 0 : n + l - 1;
    amask = '0;
    for (int i = 0; i < AS; i++)
      if (i >= off && i < off + l) amask[i] = 1'b1;
    for (int t = 0; t < tt; t++) begin
      exp = '0;
      for (int i = 0; i < AS; i++)
        if (amask[i] && t >= i - off
            && t < i - off + n)
          exp[i] = 1'b1;
      exp_q.push_back(exp);
    end

    @(negedge clk);
    weight_size  = k[15:0];
    image_height = h[15:0];
    image_width  = w[15:0];
    offset       = off[7:0];
    enable       = 1'b1;
    start        = 1'b1;
    fifo_empty   = bg & ~amask;
    @(negedge clk);
    start = 1'b0;
    #1;
    check({name, ".load_busy"}, busy, 1);
    check({name, ".load_done"}, completed, 0);

    prev = '0; beats = 0; pops = 0;
    done_c = 0; st_cnt = 0; en_cnt = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (beats == abort_beat) begin
        reset = 1'b1;
        #1;
        check({name, ".rst_re"}, read_enable_out, 0);
        check({name, ".rst_valid"}, valid_out, 0);
        check({name, ".rst_busy"}, busy, 0);
        check({name, ".rst_done"}, completed, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        return;
      end
      enable = 1'b1;
      start  = (c == start_cyc);
      stall  = 1'b0;
      fe     = bg & ~amask;
      if (beats == st_beat && st_cnt < st_len) begin
        fe[st_lane] = 1'b1;
        st_cnt++;
        stall = 1'b1;
      end
      if (beats == en_beat && en_cnt < en_len) begin
        enable = 1'b0;
        en_cnt++;
        stall = 1'b1;
      end
      fifo_empty = fe;
      #1;
      check({name, ".valid"}, valid_out, prev);
      cur = read_enable_out;
      if (completed) begin
        done_c = c;
        check({name, ".end_re"}, cur, 0);
        break;
      end
      if (stall || exp_q.size() == 0) begin
        check({name, ".idle_re"}, cur, 0);
      end else begin
        exp = exp_q.pop_front();
        check({name, ".beat"}, cur, exp);
        beats++;
      end
      pops += $countones(cur);
      prev = cur;
    end
    start  = 1'b0;
    enable = 1'b1;
    check({name, ".done_cycle"}, done_c,
          tt + 1 + st_len + en_len);
    check({name, ".pops"}, pops, n * l);
    check({name, ".left"}, exp_q.size(), 0);
    check({name, ".busy_end"}, busy, 0);
    check({name, ".done_end"}, completed, 1);
    exp_q.delete();
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    start        = 1'b0;
    weight_size  = '0;
    image_height = '0;
    image_width  = '0;
    offset       = '0;
    fifo_empty   = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset.re", read_enable_out, 0);
    check("reset.valid", valid_out, 0);
    check("reset.busy", busy, 0);
    check("reset.done", completed, 0);
    reset = 1'b0;

    run_pass("c1", 3, 5, 5, 0, 0, -1, 0,
             -1, 0, 0, -1, '0);
    run_pass("c2_stall", 3, 5, 5, 0, 4, 6, 3,
             -1, 0, 0, -1, '0);
    run_pass("c3", 2, 4, 3, 5, 0, -1, 0,
             -1, 0, 0, -1, '0);
    run_pass("c3_idle_empty", 2, 4, 3, 5, 0, -1, 0,
             -1, 0, 0, -1, 9'h01F);
    run_pass("c4_big_k", 6, 5, 5, 0, 0, -1, 0,
             -1, 0, 0, -1, '0);
    run_pass("k_zero", 0, 5, 5, 0, 0, -1, 0,
             -1, 0, 0, -1, '0);
    run_pass("off_out", 3, 5, 5, 9, 0, -1, 0,
             -1, 0, 0, -1, '0);
    run_pass("c5_abort", 3, 5, 5, 0, 0, -1, 0,
             -1, 0, 0, 7, '0);
    run_pass("c5_rerun", 3, 5, 5, 0, 0, -1, 0,
             -1, 0, 0, -1, '0);
    run_pass("c6_hold", 3, 5, 5, 0, 0, -1, 0,
             5, 4, 7, -1, '0);
    run_pass("c6_busy_start", 3, 5, 5, 0, 0, -1, 0,
             -1, 0, 4, -1, '0);
    run_pass("wide", 1, 3, 4, 2, 0, -1, 0,
             -1, 0, 0, -1, 9'h1FF);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
